program_loader: RTL and testbench

- Boot-time stage directly upstream of the miniRISC core's instruction fetch.
- Accepts a byte stream (from a UART receiver or the testbench), packs it into 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the core in reset until the image is fully loaded, then releases it.
- Output `cpu_rst` drives the core's `rst` input; the `imem_*` ports drive the write side of the instruction memory.

---
 rtl/loader_pkg.sv | 17 +
 rtl/program_loader_byte_packer.sv | 49 ++++
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader (state encoding, stream framing).
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    // Length header bytes and bytes per instruction word in the boot stream.
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: gathers big-endian bytes into 32-bit words and emits a one-cycle
// word_valid together with the completed word on the edge after the last byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] asm_p0;

    assign last_byte = (byte_idx == 2'(WORD_BYTES - 1));

    // Byte position within the current word; wraps naturally after the 4th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Assembly shift register for the first three bytes (data only, no reset).
    always_ff @(posedge clk) begin
        if (byte_valid) begin
            asm_p0 <= {asm_p0[15:0], byte_data};
        end
    end

    // Stage p1: completed word and its single-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= byte_valid && last_byte;
            if (byte_valid && last_byte) begin
                word <= {asm_p0, byte_data};
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream, writes the packed
// instruction words into instruction memory and releases the core's reset when
// the image is complete.
// Optional build macro LOADER_CHECKSUM_EN adds an XOR trailer byte check.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
    logic [7:0] csum;
`else
    localparam state_t S_AFTER_DATA = S_RUN;
`endif

    state_t      state, state_next;
    logic [15:0] length;
    logic        fire, data_fire, word_last, pk_last;
    logic [16:0] count_inc;
    logic [16:0] len_rx;
    logic        rx_ready_d, cpu_rst_d, done_d, error_d;

    assign fire      = rx_valid && rx_ready;
    assign data_fire = fire && (state == S_DATA);
    assign word_last = data_fire && pk_last;
    assign count_inc = 17'(word_count) + 17'd1;
    assign len_rx    = {1'b0, length[15:8], rx_data};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_fire),
        .byte_data  (rx_data),
        .last_byte  (pk_last),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the data phase ends on the same edge the last strobe is issued.
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI: if (fire) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (fire) begin
                    if (len_rx == 17'd0)          state_next = S_AFTER_DATA;
                    else if (len_rx > CAPACITY)   state_next = S_ERROR;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_last && (count_inc == {1'b0, length})) state_next = S_AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (fire) state_next = (rx_data == csum) ? S_RUN : S_ERROR;
            end
`endif
            default: ;
        endcase
    end

    // Output decode; done is delayed one cycle when entering run from the data
    // phase so the core only starts after the final write strobe has been seen.
    always_comb begin
        rx_ready_d = state_next inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
        done_d     = (state_next == S_RUN) && (state != S_DATA);
        cpu_rst_d  = !done_d;
        error_d    = (state_next == S_ERROR);
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            rx_ready <= rx_ready_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

    // Length header capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            length <= 16'd0;
        end else if (fire && state == S_LEN_HI) begin
            length[15:8] <= rx_data;
        end else if (fire && state == S_LEN_LO) begin
            length[7:0] <= rx_data;
        end
    end

    // Write address and word counter advance together with the write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr  <= '0;
            word_count <= '0;
        end else if (word_last) begin
            imem_addr  <= word_count[ADDR_W-1:0];
            word_count <= word_count + (ADDR_W+1)'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over data bytes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (data_fire) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (plus a narrow ADDR_W=4 copy
// for the oversize-length check).
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        rx_ready, imem_we, cpu_rst, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] word_count;

    logic        rx_ready4, imem_we4, cpu_rst4, done4, error4;
    logic [3:0]  imem_addr4;
    logic [31:0] imem_wdata4;
    logic [4:0]  word_count4;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done),
        .error(error), .word_count(word_count)
    );

    program_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .cpu_rst(cpu_rst4), .done(done4),
        .error(error4), .word_count(word_count4)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        cpu;
        logic        dn;
        logic        err;
        logic        rdy;
        logic [10:0] wc;
    } vec_t;

    vec_t tbl [26];

    int n_vec = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int we4_cnt = 0;
    bit prev_we = 1'b0;
    bit dbl_we = 1'b0;

    always @(negedge clk) begin
        if (imem_we && prev_we) dbl_we = 1'b1;
        prev_we = imem_we;
        if (imem_we) we_cnt++;
        if (imem_we4) we4_cnt++;
    end

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic we,
                                logic [9:0] addr, logic [31:0] wd, logic cpu,
                                logic dn, logic err, logic rdy, logic [10:0] wc);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.we = we; t.addr = addr; t.wd = wd;
        t.cpu = cpu; t.dn = dn; t.err = err; t.rdy = rdy; t.wc = wc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tog [6];
    logic [7:0] cs_bytes [6];

    initial begin
        // Two-word load, then the reset-mid-load restart.
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[1]  = mk(0, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 8'h02, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 8'h20, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 1, 8'h21, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 8'h05, 1, 0, 32'h20210005, 1, 0, 0, 1, 1);
        tbl[7]  = mk(0, 1, 8'h8C, 0, 0, 32'h20210005, 1, 0, 0, 1, 1);
        tbl[8]  = mk(0, 1, 8'h22, 0, 0, 32'h20210005, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 1, 8'h00, 0, 0, 32'h20210005, 1, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 8'h04, 1, 1, 32'h8C220004, 1, 0, 0, CS, 2);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 32'h8C220004, CS, !CS, 0, CS, 2);
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 32'h8C220004, CS, !CS, 0, CS, 2);
        tbl[13] = mk(1, 0, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[14] = mk(0, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[15] = mk(0, 1, 8'h01, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[16] = mk(0, 1, 8'hAA, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[17] = mk(0, 1, 8'hBB, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[18] = mk(1, 1, 8'hCC, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[19] = mk(0, 1, 8'h00, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[20] = mk(0, 1, 8'h01, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[21] = mk(0, 1, 8'h11, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[22] = mk(0, 1, 8'h22, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[23] = mk(0, 1, 8'h33, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        tbl[24] = mk(0, 1, 8'h44, 1, 0, 32'h11223344, 1, 0, 0, CS, 1);
        tbl[25] = mk(0, 0, 8'h00, 0, 0, 32'h11223344, CS, !CS, 0, CS, 1);

        tog      = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cs_bytes = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d);
            check($sformatf("v%0d.imem_we", i),    32'(imem_we),    32'(tbl[i].we));
            check($sformatf("v%0d.imem_addr", i),  32'(imem_addr),  32'(tbl[i].addr));
            check($sformatf("v%0d.imem_wdata", i), imem_wdata,      tbl[i].wd);
            check($sformatf("v%0d.cpu_rst", i),    32'(cpu_rst),    32'(tbl[i].cpu));
            check($sformatf("v%0d.done", i),       32'(done),       32'(tbl[i].dn));
            check($sformatf("v%0d.error", i),      32'(error),      32'(tbl[i].err));
            check($sformatf("v%0d.rx_ready", i),   32'(rx_ready),   32'(tbl[i].rdy));
            check($sformatf("v%0d.word_count", i), 32'(word_count), 32'(tbl[i].wc));
        end

        // Zero-length image.
        cyc(1, 0, 8'h00);
        we_cnt = 0;
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);
        check("n0.done",    32'(done),    32'(!CS));
        check("n0.cpu_rst", 32'(cpu_rst), 32'(CS));
        check("n0.ready",   32'(rx_ready), 32'(CS));
        if (CS) cyc(0, 1, 8'h00);
        cyc(0, 0, 8'h00);
        check("n0.done_hold", 32'(done), 32'd1);
        check("n0.no_write",  32'(we_cnt), 32'd0);

        // Oversize length on the 16-word instance, then exactly-full length.
        cyc(1, 0, 8'h00);
        we4_cnt = 0;
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h11);
        check("big.error",    32'(error4),    32'd1);
        check("big.ready",    32'(rx_ready4), 32'd0);
        check("big.cpu_rst",  32'(cpu_rst4),  32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'hAB);
        check("big.error_hold", 32'(error4), 32'd1);
        check("big.no_write",   32'(we4_cnt), 32'd0);
        check("big.done",       32'(done4),  32'd0);
        cyc(1, 0, 8'h00);
        check("rst.error_clr", 32'(error4), 32'd0);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h10);
        check("full.error", 32'(error4),    32'd0);
        check("full.ready", 32'(rx_ready4), 32'd1);

        // Gapped rx_valid, one word.
        cyc(1, 0, 8'h00);
        we_cnt = 0;
        dbl_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, tog[i]);
            if (i < 5) begin
                check($sformatf("gap%0d.ready_hi", i), 32'(rx_ready), 32'd1);
                cyc(0, 0, 8'h00);
                check($sformatf("gap%0d.ready_lo", i), 32'(rx_ready), 32'd1);
                check($sformatf("gap%0d.cpu_rst", i),  32'(cpu_rst),  32'd1);
            end
        end
        check("gap.we",    32'(imem_we),   32'd1);
        check("gap.addr",  32'(imem_addr), 32'd0);
        check("gap.wdata", imem_wdata,     32'hDEADBEEF);
        cyc(0, 0, 8'h00);
        check("gap.done",     32'(done),     32'(!CS));
        check("gap.we_count", 32'(we_cnt),   32'd1);
        check("gap.wc",       32'(word_count), 32'd1);
        check("gap.no_back_to_back", 32'(dbl_we), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum trailer: matching and mismatching.
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 1, cs_bytes[i]);
        cyc(0, 0, 8'h00);
        check("cs.wait_ready", 32'(rx_ready), 32'd1);
        check("cs.wait_done",  32'(done),     32'd0);
        cyc(0, 1, 8'h04);
        check("cs.ok_done",    32'(done),    32'd1);
        check("cs.ok_cpu_rst", 32'(cpu_rst), 32'd0);
        check("cs.ok_error",   32'(error),   32'd0);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 1, cs_bytes[i]);
        cyc(0, 1, 8'h05);
        check("cs.bad_error",   32'(error),   32'd1);
        check("cs.bad_cpu_rst", 32'(cpu_rst), 32'd1);
        check("cs.bad_done",    32'(done),    32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
